// File: rtl/fast_pkg.sv
// Shared types for the FAST message emitter: beat, header and FSM encodings.
// Header beat layout is {zero pad, len, id}.
package fast_pkg;

    localparam int BEAT_WIDTH     = 64;
    localparam int MSG_ID_W       = 21;
    localparam int DEF_MAX_FIELDS = 10;
    localparam int DEF_Q_DEPTH    = 4;
    localparam int LEN_W          = $clog2(DEF_MAX_FIELDS + 1);

    typedef logic [BEAT_WIDTH-1:0] beat_t;
    typedef logic [MSG_ID_W-1:0]   msg_id_t;
    typedef logic [LEN_W-1:0]      msg_len_t;

    typedef struct packed {
        msg_len_t len;
        msg_id_t  id;
    } msg_hdr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } emit_state_e;

    localparam int HDR_PAD = BEAT_WIDTH - $bits(msg_hdr_t);

    function automatic beat_t pack_hdr(msg_id_t id, msg_len_t len);
        msg_hdr_t h;
        h.len = len;
        h.id  = id;
        return {{HDR_PAD{1'b0}}, h};
    endfunction

endpackage

// File: rtl/fast_msg_emitter_if.sv
// Bundle between message-ordering stage, emitter and order-book consumer.
// master: emitter side (captures flushes, drives beat stream); slave: peers.
interface fast_msg_emitter_if #(
    parameter int MAX_FIELDS  = fast_pkg::DEF_MAX_FIELDS,
    parameter int MSG_Q_DEPTH = fast_pkg::DEF_Q_DEPTH
);
    import fast_pkg::*;

    localparam int LW = $clog2(MAX_FIELDS + 1);
    localparam int QW = $clog2(MSG_Q_DEPTH + 1);

    logic          msg_flush;
    msg_id_t       msg_id;
    logic [LW-1:0] msg_len;
    beat_t         msg_fields [MAX_FIELDS];

    logic          out_valid;
    logic          out_ready;
    beat_t         out_data;
    logic          out_hdr;
    logic          out_last;
    logic          overflow;
    logic [QW-1:0] q_level;

    modport master (
        input  msg_flush,
        input  msg_id,
        input  msg_len,
        input  msg_fields,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_hdr,
        output out_last,
        output overflow,
        output q_level
    );

    modport slave (
        output msg_flush,
        output msg_id,
        output msg_len,
        output msg_fields,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_hdr,
        input  out_last,
        input  overflow,
        input  q_level
    );

endinterface

// File: rtl/fast_msg_buf.sv
// Message queue storage: write port = capture, async read of the head entry.
// Ports: push_i/wr_*_i capture, pop_i retire head, rd_*_o head, q_level_o count.
module fast_msg_buf
    import fast_pkg::*;
#(
    parameter int MAX_FIELDS  = DEF_MAX_FIELDS,
    parameter int MSG_Q_DEPTH = DEF_Q_DEPTH,
    parameter int LW          = $clog2(MAX_FIELDS + 1),
    parameter int QW          = $clog2(MSG_Q_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic          pop_i,
    input  msg_id_t       wr_id_i,
    input  logic [LW-1:0] wr_len_i,
    input  beat_t         wr_fields_i [MAX_FIELDS],
    output msg_id_t       rd_id_o,
    output logic [LW-1:0] rd_len_o,
    output beat_t         rd_fields_o [MAX_FIELDS],
    output logic [QW-1:0] q_level_o
);

    localparam int PW = $clog2(MSG_Q_DEPTH);

    msg_id_t       id_mem  [MSG_Q_DEPTH];
    logic [LW-1:0] len_mem [MSG_Q_DEPTH];
    beat_t         fld_mem [MSG_Q_DEPTH][MAX_FIELDS];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [QW-1:0] q_level_q, q_level_d;

    // Contents are intentionally not reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i) begin
            id_mem[wr_ptr_q]  <= wr_id_i;
            len_mem[wr_ptr_q] <= wr_len_i;
            for (int i = 0; i < MAX_FIELDS; i++) begin
                fld_mem[wr_ptr_q][i] <= wr_fields_i[i];
            end
        end
    end

    always_comb begin
        rd_id_o  = id_mem[rd_ptr_q];
        rd_len_o = len_mem[rd_ptr_q];
        for (int i = 0; i < MAX_FIELDS; i++) begin
            rd_fields_o[i] = fld_mem[rd_ptr_q][i];
        end
    end

    // Pointers wrap naturally since the depth is a power of two.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        q_level_d = q_level_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push_i, pop_i})
            2'b10:   q_level_d = q_level_q + QW'(1);
            2'b01:   q_level_d = q_level_q - QW'(1);
            default: q_level_d = q_level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            q_level_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            q_level_q <= q_level_d;
        end
    end

    assign q_level_o = q_level_q;

endmodule

// File: rtl/fast_msg_emitter.sv
// Captures flushed FAST messages into a small queue and replays each one as
// a header beat followed by its field beats on a valid/ready stream.
// Ports: clk, rstn (sync, active low), bus (master modport: flush capture,
// beat stream, overflow, q_level). Optional FAST_EMIT_STATS_EN adds
// stat_msgs_out / stat_msgs_dropped saturating counters.
module fast_msg_emitter
    import fast_pkg::*;
#(
    parameter int MAX_FIELDS  = DEF_MAX_FIELDS,
    parameter int MSG_Q_DEPTH = DEF_Q_DEPTH
) (
    input  logic               clk,
    input  logic               rstn,
    fast_msg_emitter_if.master bus
`ifdef FAST_EMIT_STATS_EN
    ,
    output logic [31:0]        stat_msgs_out,
    output logic [31:0]        stat_msgs_dropped
`endif
);

    localparam int LW = $clog2(MAX_FIELDS + 1);
    localparam int QW = $clog2(MSG_Q_DEPTH + 1);

    emit_state_e   state_q, state_d;
    logic [LW-1:0] idx_q, idx_d;
    logic          overflow_q, overflow_d;

    logic [QW-1:0] q_level;
    logic          full;
    logic          push;
    logic          drop;
    logic          pop;
    logic          more;
    logic [LW-1:0] cap_len;

    msg_id_t       rd_id;
    logic [LW-1:0] rd_len;
    beat_t         rd_fields [MAX_FIELDS];

    logic          valid;
    logic          hdr;
    logic          last;
    beat_t         data;

    // Full is judged on the registered level, so a retire in the same
    // cycle cannot make room for an incoming flush.
    assign full = (q_level == QW'(MSG_Q_DEPTH));
    assign push = bus.msg_flush & ~full;
    assign drop = bus.msg_flush & full;

    assign cap_len = (bus.msg_len > LW'(MAX_FIELDS)) ?
                     LW'(MAX_FIELDS) : bus.msg_len;

    // Entries left after the retire, counting a same-cycle capture.
    assign more = (q_level != QW'(1)) | push;

    fast_msg_buf #(
        .MAX_FIELDS  (MAX_FIELDS),
        .MSG_Q_DEPTH (MSG_Q_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push),
        .pop_i       (pop),
        .wr_id_i     (bus.msg_id),
        .wr_len_i    (cap_len),
        .wr_fields_i (bus.msg_fields),
        .rd_id_o     (rd_id),
        .rd_len_o    (rd_len),
        .rd_fields_o (rd_fields),
        .q_level_o   (q_level)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid   = 1'b0;
        hdr     = 1'b0;
        last    = 1'b0;
        data    = '0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (q_level != '0) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                valid = 1'b1;
                hdr   = 1'b1;
                data  = pack_hdr(rd_id, msg_len_t'(rd_len));
                last  = (rd_len == '0);
                if (bus.out_ready) begin
                    if (last) begin
                        pop     = 1'b1;
                        state_d = more ? HDR : IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                valid = 1'b1;
                data  = rd_fields[idx_q];
                last  = (idx_q == rd_len - LW'(1));
                if (bus.out_ready) begin
                    if (last) begin
                        pop     = 1'b1;
                        state_d = more ? HDR : IDLE;
                    end else begin
                        idx_d   = idx_q + LW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign overflow_d = overflow_q | drop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.out_valid = valid;
    assign bus.out_hdr   = hdr;
    assign bus.out_last  = last;
    assign bus.out_data  = data;
    assign bus.overflow  = overflow_q;
    assign bus.q_level   = q_level;

`ifdef FAST_EMIT_STATS_EN
    logic [31:0] msgs_out_q, msgs_out_d;
    logic [31:0] msgs_drop_q, msgs_drop_d;

    always_comb begin
        msgs_out_d  = msgs_out_q;
        msgs_drop_d = msgs_drop_q;
        if (pop && (msgs_out_q != '1)) begin
            msgs_out_d = msgs_out_q + 32'd1;
        end
        if (drop && (msgs_drop_q != '1)) begin
            msgs_drop_d = msgs_drop_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            msgs_out_q  <= '0;
            msgs_drop_q <= '0;
        end else begin
            msgs_out_q  <= msgs_out_d;
            msgs_drop_q <= msgs_drop_d;
        end
    end

    assign stat_msgs_out     = msgs_out_q;
    assign stat_msgs_dropped = msgs_drop_q;
`endif

endmodule
